mem_stage_ctrl: RTL and testbench

- Memory-stage controller and MEM/WB pipeline register for the 5-stage MIPS core.
- Consumes the EX/MEM latch outputs, drives data-cache requests, and stalls upstream until dhit.
- Implements LL/SC via a link register invalidated by coherence snoops.
- Captures load, ALU and SC results into the WB-stage register.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/link_reg.sv | 44 ++++
 rtl/mem_stage_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared core types: data word, register index, and memory-stage FSM states.
package cpu_types_pkg;

  localparam int unsigned LINK_CMP_LSB = 2;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    RUN,
    HOLD,
    HALTED
  } memstate_t;

endpackage

// File: rtl/link_reg.sv
// LL/SC link register: records the word reserved by LL and drops it on
// SC, a local store to that word, or a coherence invalidate of that word.
module link_reg #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned CMP_LSB = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ll_set,
  input  logic [WORD_W-1:0] ll_addr,
  input  logic              clr,
  input  logic              inv,
  input  logic [WORD_W-1:0] inv_addr,
  input  logic [WORD_W-1:0] chk_addr,
  output logic              valid,
  output logic              match
);

  logic [WORD_W-1:0] link_addr_q;
  logic              link_valid_q;
  logic              inv_hits_link;
  logic              inv_hits_ll;

  assign inv_hits_link = inv && (inv_addr[WORD_W-1:CMP_LSB] == link_addr_q[WORD_W-1:CMP_LSB]);
  assign inv_hits_ll   = inv && (inv_addr[WORD_W-1:CMP_LSB] == ll_addr[WORD_W-1:CMP_LSB]);

  assign valid = link_valid_q;
  assign match = link_valid_q &&
                 (chk_addr[WORD_W-1:CMP_LSB] == link_addr_q[WORD_W-1:CMP_LSB]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_addr_q  <= '0;
      link_valid_q <= 1'b0;
    end else if (ll_set) begin
      // A snoop to the word being linked this very cycle kills the new reservation.
      link_addr_q  <= ll_addr;
      link_valid_q <= !inv_hits_ll;
    end else if (clr || inv_hits_link) begin
      link_valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller and MEM/WB register: dcache requests, stall until
// dhit, LL/SC via link_reg, and a HOLD state that parks a finished access.
module mem_stage_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W       = 32,
  parameter int unsigned LINK_CMP_LSB = cpu_types_pkg::LINK_CMP_LSB
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              memRd_MEM,
  input  logic              memWr_MEM,
  input  logic              datomic_MEM,
  input  logic              RegWr_MEM,
  input  logic              halt_MEM,
  input  logic [4:0]        wsel_MEM,
  input  logic [WORD_W-1:0] aluout_MEM,
  input  logic [WORD_W-1:0] busB_MEM,
  input  logic              wb_enable,
  input  logic              wb_flush,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dload,
  input  logic              ccinv,
  input  logic [WORD_W-1:0] ccinv_addr,
  output logic              dREN,
  output logic              dWEN,
  output logic [WORD_W-1:0] daddr,
  output logic [WORD_W-1:0] dstore,
  output logic              mem_stall,
  output logic              RegWr_WB,
  output logic [4:0]        wsel_WB,
  output logic [WORD_W-1:0] wdat_WB,
  output logic              halt_WB,
  output logic              halted
);

  memstate_t         state_q, state_d;
  logic [WORD_W-1:0] hold_q;
  logic              link_valid;
  logic              link_match;
  logic              sc_op, ll_op, mem_op, sc_fail;
  logic              ren_c, wen_c, stall_c, in_run, commit, park;
  logic              ll_set, link_clr;
  logic [WORD_W-1:0] result, commit_data;

  assign sc_op   = memWr_MEM && datomic_MEM;
  assign ll_op   = memRd_MEM && datomic_MEM;
  assign mem_op  = memRd_MEM || memWr_MEM;
  assign sc_fail = sc_op && !link_match;
  assign in_run  = (state_q == RUN);

  assign result = memRd_MEM ? dload :
                  sc_op     ? {{(WORD_W-1){1'b0}}, !sc_fail} :
                              aluout_MEM;

  always_comb begin
    ren_c   = 1'b0;
    wen_c   = 1'b0;
    stall_c = 1'b0;
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        ren_c   = memRd_MEM;
        wen_c   = memWr_MEM && !sc_fail;
        stall_c = (ren_c || wen_c) && !dhit;
      end
      HOLD:    stall_c = !wb_enable;
      HALTED:  ;
      default: ;
    endcase

    commit = wb_enable && ((in_run && !stall_c) || (state_q == HOLD));
    park   = in_run && !stall_c && !wb_enable && mem_op;

    if (park) begin
      state_d = HOLD;
    end else if (commit && !wb_flush && halt_MEM) begin
      state_d = HALTED;
    end else if (commit && (state_q == HOLD)) begin
      state_d = RUN;
    end
  end

  // Requests fall the instant reset asserts so a half-done store never lands.
  assign dREN      = nRST && ren_c;
  assign dWEN      = nRST && wen_c;
  assign mem_stall = nRST && stall_c;
  assign daddr     = aluout_MEM;
  assign dstore    = busB_MEM;
  assign halted    = (state_q == HALTED);

  assign ll_set   = in_run && ll_op && dhit;
  assign link_clr = in_run && ((sc_op && (dhit || sc_fail)) ||
                               (memWr_MEM && !datomic_MEM && dhit && link_match));

  link_reg #(
    .WORD_W  (WORD_W),
    .CMP_LSB (LINK_CMP_LSB)
  ) u_link_reg (
    .clk      (CLK),
    .rst_n    (nRST),
    .ll_set   (ll_set),
    .ll_addr  (aluout_MEM),
    .clr      (link_clr),
    .inv      (ccinv),
    .inv_addr (ccinv_addr),
    .chk_addr (aluout_MEM),
    .valid    (link_valid),
    .match    (link_match)
  );

  assign commit_data = (state_q == HOLD) ? hold_q : result;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (park) hold_q <= result;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      RegWr_WB <= 1'b0;
      wsel_WB  <= '0;
      wdat_WB  <= '0;
      halt_WB  <= 1'b0;
    end else if (wb_enable) begin
      if (wb_flush) begin
        RegWr_WB <= 1'b0;
        wsel_WB  <= '0;
        wdat_WB  <= '0;
        halt_WB  <= 1'b0;
      end else if (commit) begin
        RegWr_WB <= RegWr_MEM;
        wsel_WB  <= wsel_MEM;
        wdat_WB  <= commit_data;
        halt_WB  <= halt_MEM;
      end else if (in_run && stall_c) begin
        RegWr_WB <= 1'b0;
        halt_WB  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: loads, LL/SC with snoops, HOLD, halt, reset.
module tb_mem_stage_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        memRd_MEM, memWr_MEM, datomic_MEM, RegWr_MEM, halt_MEM;
  logic [4:0]  wsel_MEM;
  logic [31:0] aluout_MEM, busB_MEM;
  logic        wb_enable, wb_flush, dhit, ccinv;
  logic [31:0] dload, ccinv_addr;
  logic        dREN, dWEN, mem_stall, RegWr_WB, halt_WB, halted;
  logic [31:0] daddr, dstore, wdat_WB;
  logic [4:0]  wsel_WB;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 CLK = ~CLK;

  mem_stage_ctrl dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .memRd_MEM   (memRd_MEM),
    .memWr_MEM   (memWr_MEM),
    .datomic_MEM (datomic_MEM),
    .RegWr_MEM   (RegWr_MEM),
    .halt_MEM    (halt_MEM),
    .wsel_MEM    (wsel_MEM),
    .aluout_MEM  (aluout_MEM),
    .busB_MEM    (busB_MEM),
    .wb_enable   (wb_enable),
    .wb_flush    (wb_flush),
    .dhit        (dhit),
    .dload       (dload),
    .ccinv       (ccinv),
    .ccinv_addr  (ccinv_addr),
    .dREN        (dREN),
    .dWEN        (dWEN),
    .daddr       (daddr),
    .dstore      (dstore),
    .mem_stall   (mem_stall),
    .RegWr_WB    (RegWr_WB),
    .wsel_WB     (wsel_WB),
    .wdat_WB     (wdat_WB),
    .halt_WB     (halt_WB),
    .halted      (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nop();
    memRd_MEM = 0; memWr_MEM = 0; datomic_MEM = 0; RegWr_MEM = 0; halt_MEM = 0;
    wsel_MEM = 0; aluout_MEM = 0; busB_MEM = 0; dhit = 0; dload = 0;
    ccinv = 0; ccinv_addr = 0; wb_flush = 0; wb_enable = 1;
  endtask

  // Advance one edge and settle to a point well away from it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic op_ll(input logic [31:0] a);
    nop(); memRd_MEM = 1; datomic_MEM = 1; RegWr_MEM = 1; wsel_MEM = 2;
    aluout_MEM = a; dhit = 1; dload = 32'h77;
    tick();
  endtask

  task automatic op_sc(input logic [31:0] a, input logic hit);
    nop(); memWr_MEM = 1; datomic_MEM = 1; RegWr_MEM = 1; wsel_MEM = 3;
    aluout_MEM = a; busB_MEM = 32'h5; dhit = hit;
  endtask

  initial begin
    nop();
    nRST = 0;
    #2;
    check("rst_dren", {31'b0, dREN}, 0);
    check("rst_dwen", {31'b0, dWEN}, 0);
    check("rst_stall", {31'b0, mem_stall}, 0);
    check("rst_wb", {RegWr_WB, halt_WB, halted, wsel_WB, wdat_WB[23:0]}, 0);
    tick();
    nRST = 1;
    tick();

    // LW 0x100, dhit on third cycle.
    nop(); memRd_MEM = 1; RegWr_MEM = 1; wsel_MEM = 5; aluout_MEM = 32'h100;
    #1;
    check("lw_c1_dren", {31'b0, dREN}, 1);
    check("lw_c1_stall", {31'b0, mem_stall}, 1);
    check("lw_daddr", daddr, 32'h100);
    tick();
    check("lw_c1_bubble", {31'b0, RegWr_WB}, 0);
    check("lw_c2_stall", {31'b0, mem_stall}, 1);
    tick();
    dhit = 1; dload = 32'hDEADBEEF;
    #1;
    check("lw_c3_dren", {31'b0, dREN}, 1);
    check("lw_c3_stall", {31'b0, mem_stall}, 0);
    tick();
    check("lw_regwr", {31'b0, RegWr_WB}, 1);
    check("lw_wdat", wdat_WB, 32'hDEADBEEF);
    check("lw_wsel", {27'b0, wsel_WB}, 5);

    // LL/SC success, then a second SC must fail.
    op_ll(32'h200);
    check("ll_wdat", wdat_WB, 32'h77);
    op_sc(32'h200, 1);
    #1;
    check("sc_dwen", {31'b0, dWEN}, 1);
    check("sc_dstore", dstore, 32'h5);
    tick();
    check("sc_wdat", wdat_WB, 1);
    op_sc(32'h200, 0);
    #1;
    check("sc2_dwen", {31'b0, dWEN}, 0);
    check("sc2_stall", {31'b0, mem_stall}, 0);
    tick();
    check("sc2_wdat", wdat_WB, 0);

    // Snoop to a neighbouring word leaves the link alone.
    op_ll(32'h300);
    nop(); ccinv = 1; ccinv_addr = 32'h304; tick();
    op_sc(32'h300, 1);
    #1;
    check("snoop_miss_dwen", {31'b0, dWEN}, 1);
    tick();
    check("snoop_miss_wdat", wdat_WB, 1);

    // Non-matching then matching snoop kills the link.
    op_ll(32'h200);
    nop(); ccinv = 1; ccinv_addr = 32'h204; tick();
    nop(); ccinv = 1; ccinv_addr = 32'h200; tick();
    op_sc(32'h200, 0);
    #1;
    check("snoop_hit_dwen", {31'b0, dWEN}, 0);
    check("snoop_hit_stall", {31'b0, mem_stall}, 0);
    tick();
    check("snoop_hit_wdat", wdat_WB, 0);

    // Byte offset within the linked word still counts as a hit.
    op_ll(32'h280);
    nop(); ccinv = 1; ccinv_addr = 32'h282; tick();
    op_sc(32'h280, 0);
    #1;
    check("snoop_byte_dwen", {31'b0, dWEN}, 0);
    tick();

    // Plain SW to the linked word breaks the link.
    op_ll(32'h400);
    nop(); memWr_MEM = 1; aluout_MEM = 32'h400; dhit = 1; tick();
    op_sc(32'h400, 0);
    #1;
    check("sw_kill_dwen", {31'b0, dWEN}, 0);
    tick();

    // Invalidate racing the LL completion wins.
    nop(); memRd_MEM = 1; datomic_MEM = 1; RegWr_MEM = 1; aluout_MEM = 32'h500;
    dhit = 1; ccinv = 1; ccinv_addr = 32'h500; tick();
    op_sc(32'h500, 0);
    #1;
    check("race_dwen", {31'b0, dWEN}, 0);
    tick();

    // SC completes while WB is blocked: park in HOLD, write once.
    op_ll(32'h600);
    op_sc(32'h600, 1); wb_enable = 0;
    #1;
    check("hold_sc_dwen", {31'b0, dWEN}, 1);
    check("hold_sc_stall", {31'b0, mem_stall}, 0);
    tick();
    check("hold_wb_kept", {27'b0, wsel_WB}, 2);
    check("hold1_dwen", {31'b0, dWEN}, 0);
    check("hold1_stall", {31'b0, mem_stall}, 1);
    tick();
    check("hold2_dwen", {31'b0, dWEN}, 0);
    wb_enable = 1;
    #1;
    check("hold3_dwen", {31'b0, dWEN}, 0);
    check("hold3_stall", {31'b0, mem_stall}, 0);
    tick();
    check("hold_wdat", wdat_WB, 1);
    check("hold_wsel", {27'b0, wsel_WB}, 3);

    // Flush beats commit.
    nop(); RegWr_MEM = 1; wsel_MEM = 9; aluout_MEM = 32'h1234; wb_flush = 1; tick();
    check("flush_wb", {RegWr_WB, wsel_WB, wdat_WB[25:0]}, 0);

    // Halt, then a load must not issue; reset clears halted.
    nop(); halt_MEM = 1; tick();
    check("halt_wb", {31'b0, halt_WB}, 1);
    check("halted", {31'b0, halted}, 1);
    nop(); memRd_MEM = 1; RegWr_MEM = 1; aluout_MEM = 32'h100;
    #1;
    check("halted_dren", {31'b0, dREN}, 0);
    check("halted_stall", {31'b0, mem_stall}, 0);
    tick();
    nRST = 0;
    #1;
    check("halt_rst", {30'b0, halted, halt_WB}, 0);
    tick();
    nop(); nRST = 1; tick();

    // Reset mid-store.
    nop(); RegWr_MEM = 1; wsel_MEM = 7; aluout_MEM = 32'hABC; tick();
    check("alu_wdat", wdat_WB, 32'hABC);
    nop(); memWr_MEM = 1; aluout_MEM = 32'h800; busB_MEM = 32'h1234;
    #1;
    check("st_dwen", {31'b0, dWEN}, 1);
    nRST = 0;
    #1;
    check("st_rst_dwen", {31'b0, dWEN}, 0);
    check("st_rst_stall", {31'b0, mem_stall}, 0);
    check("st_rst_wb", {RegWr_WB, halt_WB, wsel_WB, wdat_WB[24:0]}, 0);
    check("st_rst_wdat", wdat_WB, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
